motoro3_speed_sequencer: RTL and testbench

Command-driven run controller for the three-phase motor drive: it accepts target-speed/direction commands over a valid/ready handshake and sequences the drive's `m3start`, `m3forceStop`, `m3invRotate`, `m3freqINC` and `m3freqDEC` control inputs. It ramps the frequency one step at a time at a programmable rate and handles direction reversal by decelerating to zero, flipping rotation, then re-accelerating. It sits between the host/command logic and the motor drive top level.

---
 rtl/motoro3_speed_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_motoro3_speed_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_speed_sequencer.sv
// Run sequencer for the three-phase drive: one frequency step per RAMP_DIV cycles, reversal via zero. Optional watchdog: MOTORO3_SEQ_WDOG_EN.
// Latency: accept -> START on the next edge; first step START_HOLD+RAMP_DIV edges after accept; all outputs except cmdReady registered.
// Backpressure: cmdReady only in IDLE/RUN with estop low; estop overrides everything and blocks accepts.
module motoro3_speed_sequencer #(
    parameter int RAMP_DIV    = 10000,
    parameter int START_HOLD  = 100,
    parameter int FREQ_MAX    = 1000,
    parameter int WDOG_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [9:0] cmdFreq,
    input  logic       cmdInv,
    input  logic       estop,
    output logic       m3start,
    output logic       m3forceStop,
    output logic       m3invRotate,
    output logic       m3freqINC,
    output logic       m3freqDEC,
    output logic [9:0] curFreq,
    output logic       busy,
    output logic [2:0] seqState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        BRAKE = 3'd4
    } stateT;

    localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(RAMP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(START_HOLD - 1);
    localparam logic [9:0]        FREQ_CLAMP = 10'(FREQ_MAX);

    stateT             state, stateNxt;
    logic [9:0]        tgtFreq, tgtFreqNxt;
    logic              tgtInv, tgtInvNxt;
    logic [PRE_W-1:0]  preCnt, preNxt;
    logic [HOLD_W-1:0] holdCnt, holdNxt;
    logic [9:0]        freqNxt;
    logic              invNxt, incNxt, decNxt;
    logic              startNxt, forceNxt, busyNxt;
    logic              accept, reversal, wdogHit;
    logic [9:0]        clampFreq;

    assign cmdReady  = ((state == IDLE) || (state == RUN)) && !estop;
    assign accept    = cmdValid && cmdReady;
    assign clampFreq = (cmdFreq > FREQ_CLAMP) ? FREQ_CLAMP : cmdFreq;
    assign reversal  = (tgtInv != m3invRotate);
    assign seqState  = state;

`ifdef MOTORO3_SEQ_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdogCnt;

    assign wdogHit = (state == RUN) && (wdogCnt == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdogCnt <= '0;
        end else if (accept || (stateNxt == RUN && state != RUN)) begin
            wdogCnt <= '0;
        end else if (state == RUN && !wdogHit) begin
            wdogCnt <= wdogCnt + 32'd1;
        end
    end
`else
    // No watchdog: RUN holds indefinitely (constant 0 for any legal WDOG_CYCLES).
    assign wdogHit = (WDOG_CYCLES < 0);
`endif

    always_comb begin
        stateNxt   = state;
        tgtFreqNxt = tgtFreq;
        tgtInvNxt  = tgtInv;
        preNxt     = preCnt;
        holdNxt    = holdCnt;
        freqNxt    = curFreq;
        invNxt     = m3invRotate;
        incNxt     = 1'b0;
        decNxt     = 1'b0;
        if (estop) begin
            stateNxt = BRAKE;
            freqNxt  = '0;
            preNxt   = '0;
            holdNxt  = '0;
        end else begin
            if (accept) begin
                tgtFreqNxt = clampFreq;
                tgtInvNxt  = cmdInv;
            end
            case (state)
                IDLE: begin
                    if (accept && clampFreq != 10'd0) begin
                        stateNxt = START;
                        invNxt   = cmdInv;
                        holdNxt  = '0;
                    end
                end
                START: begin
                    if (holdCnt == HOLD_LAST) begin
                        stateNxt = RAMP;
                        preNxt   = '0;
                    end else begin
                        holdNxt = holdCnt + 1'b1;
                    end
                end
                RAMP: begin
                    if (preCnt == PRE_LAST) begin
                        preNxt = '0;
                        // Reversal always drains to zero before the direction flips.
                        if (reversal) begin
                            if (curFreq != 10'd0) begin
                                decNxt  = 1'b1;
                                freqNxt = curFreq - 10'd1;
                            end else begin
                                invNxt = !m3invRotate;
                            end
                        end else if (curFreq < tgtFreq) begin
                            incNxt  = 1'b1;
                            freqNxt = curFreq + 10'd1;
                        end else if (curFreq > tgtFreq) begin
                            decNxt  = 1'b1;
                            freqNxt = curFreq - 10'd1;
                        end else begin
                            stateNxt = (tgtFreq == 10'd0) ? IDLE : RUN;
                        end
                    end else begin
                        preNxt = preCnt + 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        stateNxt = RAMP;
                        preNxt   = '0;
                    end else if (wdogHit) begin
                        stateNxt   = RAMP;
                        preNxt     = '0;
                        tgtFreqNxt = '0;
                    end
                end
                BRAKE:   stateNxt = IDLE;
                default: stateNxt = IDLE;
            endcase
        end
        startNxt = (stateNxt == START) || (stateNxt == RAMP) || (stateNxt == RUN);
        forceNxt = (stateNxt == BRAKE);
        busyNxt  = (stateNxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tgtFreq     <= '0;
            tgtInv      <= 1'b0;
            preCnt      <= '0;
            holdCnt     <= '0;
            curFreq     <= '0;
            m3invRotate <= 1'b0;
            m3freqINC   <= 1'b0;
            m3freqDEC   <= 1'b0;
            m3start     <= 1'b0;
            m3forceStop <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= stateNxt;
            tgtFreq     <= tgtFreqNxt;
            tgtInv      <= tgtInvNxt;
            preCnt      <= preNxt;
            holdCnt     <= holdNxt;
            curFreq     <= freqNxt;
            m3invRotate <= invNxt;
            m3freqINC   <= incNxt;
            m3freqDEC   <= decNxt;
            m3start     <= startNxt;
            m3forceStop <= forceNxt;
            busy        <= busyNxt;
        end
    end

endmodule

// File: tb/tb_motoro3_speed_sequencer.sv
// Bench for motoro3_speed_sequencer: directed and random commands checked against a pulse-count/timing model.
module tb_motoro3_speed_sequencer;

    localparam int RD = 4;
    localparam int SH = 3;
    localparam int FM = 1000;
    localparam int WD = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic [9:0] cmdFreq;
    logic       cmdInv;
    logic       estop;
    logic       m3start;
    logic       m3forceStop;
    logic       m3invRotate;
    logic       m3freqINC;
    logic       m3freqDEC;
    logic [9:0] curFreq;
    logic       busy;
    logic [2:0] seqState;

    int nCmp = 0;
    int nBad = 0;

    // Model: applied frequency, direction, and whether the block rests in IDLE(0) or RUN(3).
    int mCur   = 0;
    bit mDir   = 1'b0;
    int mState = 0;

    int scratchA;
    int scratchB;
    int scratchC;

    motoro3_speed_sequencer #(
        .RAMP_DIV   (RD),
        .START_HOLD (SH),
        .FREQ_MAX   (FM),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdFreq    (cmdFreq),
        .cmdInv     (cmdInv),
        .estop      (estop),
        .m3start    (m3start),
        .m3forceStop(m3forceStop),
        .m3invRotate(m3invRotate),
        .m3freqINC  (m3freqINC),
        .m3freqDEC  (m3freqDEC),
        .curFreq    (curFreq),
        .busy       (busy),
        .seqState   (seqState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it until the block settles in RUN or IDLE.
    task automatic sendCmd(input int f, input bit inv, input string tag);
        int tgt, expInc, expDec, expTog, expK;
        int nInc, nDec, nTog, firstK, togK, endK, lastK;
        int overlap, spacing, startLow, forced, anomalies;
        bit fromIdle, prevInv, done;
        tgt      = (f > FM) ? FM : f;
        fromIdle = (mState == 0);
        expInc   = 0;
        expDec   = 0;
        expTog   = 0;
        if (fromIdle) expInc = tgt;
        else if (inv != mDir) begin
            expDec = mCur;
            expTog = 1;
            expInc = tgt;
        end else if (tgt >= mCur) expInc = tgt - mCur;
        else expDec = mCur - tgt;
        expK = RD * (expDec + expTog + expInc + 1) + (fromIdle ? SH : 0);

        cmdFreq  = 10'(f);
        cmdInv   = inv;
        cmdValid = 1'b1;
        check({tag, "_ready"}, cmdReady, 1);
        tick();
        cmdValid = 1'b0;

        if (fromIdle && tgt == 0) begin
            anomalies = 0;
            for (int k = 0; k < 2 * RD; k++) begin
                tick();
                if (m3freqINC || m3freqDEC || seqState != 3'd0 || m3start) anomalies++;
            end
            check({tag, "_noop_activity"}, anomalies, 0);
            check({tag, "_noop_dir"}, m3invRotate, mDir);
            check({tag, "_noop_busy"}, busy, 0);
        end else begin
            if (fromIdle) begin
                check({tag, "_start_state"}, seqState, 1);
                check({tag, "_start_run"}, m3start, 1);
                check({tag, "_start_busy"}, busy, 1);
                check({tag, "_start_dir"}, m3invRotate, inv);
            end else begin
                check({tag, "_ramp_state"}, seqState, 2);
            end
            nInc = 0; nDec = 0; nTog = 0; firstK = -1; togK = -1; endK = -1;
            lastK = -1000; overlap = 0; spacing = 0; startLow = 0; forced = 0;
            prevInv = m3invRotate;
            done = 1'b0;
            for (int k = 1; k <= expK + 20 && !done; k++) begin
                tick();
                if (m3freqINC && m3freqDEC) overlap++;
                if (m3freqINC || m3freqDEC) begin
                    if (k - lastK < RD) spacing++;
                    lastK = k;
                    if (firstK < 0) firstK = k;
                end
                if (m3freqINC) nInc++;
                if (m3freqDEC) nDec++;
                if (m3invRotate != prevInv) begin
                    nTog++;
                    if (togK < 0) togK = k;
                    prevInv = m3invRotate;
                end
                if (m3forceStop) forced++;
                if (seqState == 3'd0 || seqState == 3'd3) begin
                    done = 1'b1;
                    endK = k;
                end else if (!m3start) startLow++;
            end
            check({tag, "_settle_cycle"}, endK, expK);
            check({tag, "_inc_count"}, nInc, expInc);
            check({tag, "_dec_count"}, nDec, expDec);
            check({tag, "_toggles"}, nTog, expTog);
            if (expTog != 0) check({tag, "_toggle_cycle"}, togK, RD * (expDec + 1));
            if (expInc + expDec != 0) check({tag, "_first_pulse"}, firstK, fromIdle ? SH + RD : RD);
            check({tag, "_freq"}, curFreq, tgt);
            check({tag, "_dir"}, m3invRotate, inv);
            check({tag, "_state"}, seqState, (tgt == 0) ? 0 : 3);
            check({tag, "_run_level"}, m3start, (tgt != 0));
            check({tag, "_overlap"}, overlap, 0);
            check({tag, "_spacing"}, spacing, 0);
            check({tag, "_start_low"}, startLow, 0);
            check({tag, "_force"}, forced, 0);
            mCur   = tgt;
            mDir   = inv;
            mState = (tgt == 0) ? 0 : 3;
        end
    endtask

    initial begin
        rst      = 1'b1;
        estop    = 1'b0;
        cmdValid = 1'b0;
        cmdFreq  = '0;
        cmdInv   = 1'b0;
        #1;
        check("rst_ready", cmdReady, 1);
        check("rst_state", seqState, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("rel_outs", {m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, busy}, 0);
        check("rel_freq", curFreq, 0);
        check("rel_state", seqState, 0);
        check("rel_ready", cmdReady, 1);

        sendCmd(5, 1'b0, "up5");
        sendCmd(2, 1'b0, "down2");
        sendCmd(0, 1'b0, "down0");
        sendCmd(3, 1'b0, "up3");
        sendCmd(2, 1'b1, "rev2");
        sendCmd(2, 1'b1, "same2");
        sendCmd(0, 1'b1, "idle_zero");
        sendCmd(0, 1'b0, "noop_zero");
        sendCmd(2, 1'b1, "up2inv");

        // Emergency stop while ramping up through 4.
        cmdFreq  = 10'd8;
        cmdInv   = 1'b1;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        scratchA = 0;
        while (curFreq != 10'd4 && scratchA < 100) begin
            tick();
            scratchA++;
        end
        check("es_reach4", curFreq, 4);
        check("es_ramp_ready", cmdReady, 0);
        estop    = 1'b1;
        cmdFreq  = 10'd3;
        cmdInv   = 1'b0;
        cmdValid = 1'b1;
        #1;
        check("es_ready_low", cmdReady, 0);
        tick();
        check("es_state", seqState, 4);
        check("es_force", m3forceStop, 1);
        check("es_run", m3start, 0);
        check("es_freq", curFreq, 0);
        check("es_pulse", {m3freqINC, m3freqDEC}, 0);
        check("es_busy", busy, 1);
        check("es_dir_held", m3invRotate, 1);
        scratchB = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m3freqINC || m3freqDEC || seqState != 3'd4 || curFreq != 10'd0) scratchB++;
        end
        check("es_hold", scratchB, 0);
        estop    = 1'b0;
        cmdValid = 1'b0;
        tick();
        check("es_release_state", seqState, 0);
        check("es_release_force", m3forceStop, 0);
        check("es_release_busy", busy, 0);
        check("es_release_ready", cmdReady, 1);
        mCur   = 0;
        mState = 0;

        for (int i = 0; i < 10; i++) begin
            sendCmd(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        sendCmd(1023, 1'($urandom_range(0, 1)), "clamp");
        estop = 1'b1;
        tick();
        check("clamp_brake_freq", curFreq, 0);
        estop = 1'b0;
        tick();
        check("clamp_brake_idle", seqState, 0);
        mCur   = 0;
        mState = 0;

        // Asynchronous reset in the middle of a ramp.
        cmdFreq  = 10'd6;
        cmdInv   = 1'b1;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
        repeat (12) tick();
        check("ar_pre_freq", curFreq, 2);
        #2 rst = 1'b1;
        #1;
        check("ar_outs", {m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, busy}, 0);
        check("ar_freq", curFreq, 0);
        check("ar_state", seqState, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_release_state", seqState, 0);
        mCur   = 0;
        mDir   = 1'b0;
        mState = 0;

`ifdef MOTORO3_SEQ_WDOG_EN
        sendCmd(2, 1'b0, "wd_arm");
        scratchA = -1;
        scratchB = 0;
        scratchC = -1;
        for (int k = 1; k <= WD + 40 && scratchC < 0; k++) begin
            tick();
            if (scratchA < 0 && seqState != 3'd3) scratchA = k;
            if (m3freqDEC) scratchB++;
            if (scratchA >= 0 && seqState == 3'd0) scratchC = k;
        end
        check("wd_timeout_cycle", scratchA, WD);
        check("wd_dec_count", scratchB, 2);
        check("wd_idle_cycle", scratchC, WD + 3 * RD);
        check("wd_run_low", m3start, 0);
        mCur   = 0;
        mState = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
